chacha_keystream_serializer: RTL
================================

Name: chacha_keystream_serializer

Overview:
- Downstream stage of the ChaCha20 round engine.
- On each completed 20-round block it performs the feed-forward addition (round output + original input state, word-wise mod 2^32).
- It buffers the 16 resulting keystream words and streams them one 32-bit word per transfer over a valid/ready handshake to the cipher XOR stage.
- It tracks emitted-block count and flags blocks lost because the buffer was still busy.

Parameters:
- WORD_W, 32, keystream word width (ChaCha20 fixes 32; not meant to be changed).
- CNT_W, 16, width of blocks_emitted counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_state  in  word_t [3:0][3:0]  matrix originally fed to the round engine ([row][col]).
- round_state  in  word_t [3:0][3:0]  round engine output matrix.
- block_ready  in  1  single-cycle pulse: round_state valid this cycle.
- ks_word  out  WORD_W  keystream word.
- ks_valid  out  1  ks_word valid.
- ks_ready  in  1  consumer accepts ks_word.
- ks_last  out  1  high with word index 15.
- busy  out  1  high whenever state != IDLE.
- block_overrun  out  1  sticky error: block_ready arrived while busy.
- blocks_emitted  out  CNT_W  count of fully streamed blocks, wraps.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - ks_word=0, ks_valid=0, ks_last=0, busy=0, block_overrun=0, blocks_emitted=0.
  - Word index=0; capture registers=0.
- States: IDLE, CAPTURE, ADD, STREAM.
- IDLE:
  - block_ready=1 at edge N: latch init_state and round_state into capture regs; go CAPTURE.
- CAPTURE (edge N+1): go ADD. This is a one-cycle register stage that isolates the wide input bus from the adders.
- ADD (edge N+2):
  - buf[k] = init[k] + round[k], truncated to 32 bits, for k = 4*row+col, k=0..15.
  - Index=0; go STREAM.
- STREAM:
  - ks_valid=1 from the cycle after edge N+2 (first valid at cycle N+3).
  - ks_word=buf[index]; ks_last=(index==15).
  - ks_word is held stable while ks_valid=1 and ks_ready=0.
  - On an edge with ks_valid & ks_ready: index increments.
  - If index was 15: ks_valid drops, blocks_emitted increments (wraps 2^CNT_W-1 -> 0), go IDLE.
- Word order: row-major k=0..15. Each word is emitted as a native 32-bit value; the consumer handles little-endian byte serialization.
- ks_ready high every cycle gives 16 consecutive transfers, so one block takes 19 cycles from block_ready to return to IDLE.
- New block while busy: block_ready in CAPTURE, ADD or STREAM is ignored (no capture) and block_overrun is set. block_overrun clears only on reset.
- block_ready in the same cycle as the final handshake (index 15): the FSM is still busy that cycle, so the pulse is an overrun. Back-to-back acceptance requires block_ready on or after the first IDLE cycle.
- ks_ready high outside STREAM: no effect.
- Reset mid-stream: immediate return to reset values. The partial block is dropped and not counted.
- Adders are modulo 2^32; carry out is discarded.

Decomposition:
- Shared package chacha_pkg:
  - word_t (logic [31:0]).
  - matrix_t (word_t [3:0][3:0]).
  - CHACHA_CONST0..3 (61707865, 3320646e, 79622d32, 6b206574).
  - Serializer state enum ks_state_t.
- One natural sub-module: chacha_feedforward_add. It is combinational: 16 parallel 32-bit adders, matrix_t in x2 -> word_t[15:0] out. It is reusable by the future block-function wrapper.
- FSM, buffer and handshake stay in the top module.

Test Plan:
- RFC 8439 2.3.2 vector:
  - init word0=61707865, round word0=837778ab, init word1=3320646e, round word1=e238d763.
  - Pulse block_ready, ks_ready=1.
  - Expect ks_word e4e7f110 at cycle N+3, then 15593bd1.
  - 16 transfers total, ks_last only on the 16th, blocks_emitted=1, busy low at N+19.
- Backpressure:
  - init all 00000001, round[k]=k; ks_ready toggles 1/0 each cycle.
  - Words 00000001..00000010 in order; ks_word stable while stalled; 32 cycles of streaming.
- Wrap arithmetic: init all ffffffff, round all 00000002 -> every word 00000001.
- Overrun:
  - Second block_ready during STREAM at index 5.
  - Expect block_overrun=1 (sticky), the first block streams unchanged, blocks_emitted=1 only.
- Reset mid-stream:
  - Assert rst_n=0 asynchronously at index 8 (mid-cycle).
  - Outputs clear immediately without a clock edge; blocks_emitted=0.
  - After release, a new block streams from word 0.
- Counter wrap:
  - Force blocks_emitted to ffff, complete one block -> 0000.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared ChaCha20 types, constants and the keystream serializer state encoding.
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [3:0][3:0] matrix_t;

  localparam word_t CHACHA_CONST0 = 32'h6170_7865;
  localparam word_t CHACHA_CONST1 = 32'h3320_646e;
  localparam word_t CHACHA_CONST2 = 32'h7962_2d32;
  localparam word_t CHACHA_CONST3 = 32'h6b20_6574;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_CAPTURE,
    KS_ADD,
    KS_STREAM
  } ks_state_t;

endpackage

// File: rtl/chacha_feedforward_add.sv
// ChaCha20 feed-forward: 16 parallel mod-2^32 adders, output flattened row-major.
module chacha_feedforward_add
  import chacha_pkg::*;
(
  input  matrix_t      init_i,
  input  matrix_t      round_i,
  output word_t [15:0] sum_o
);

  always_comb begin
    sum_o = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        sum_o[4*r+c] = init_i[r][c] + round_i[r][c];
      end
    end
  end

endmodule

// File: rtl/chacha_keystream_serializer.sv
// Feed-forward adds a finished ChaCha20 block and streams its 16 keystream
// words over valid/ready, counting emitted blocks and flagging overruns.
module chacha_keystream_serializer
  import chacha_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  matrix_t           init_state,
  input  matrix_t           round_state,
  input  logic              block_ready,
  output logic [WORD_W-1:0] ks_word,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic              ks_last,
  output logic              busy,
  output logic              block_overrun,
  output logic [CNT_W-1:0]  blocks_emitted
);

  ks_state_t        state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             cap_en, buf_en;
  matrix_t          init_q, round_q;
  word_t [15:0]     buf_q;
  word_t [15:0]     sum_w;

  chacha_feedforward_add u_ffadd (
    .init_i  (init_q),
    .round_i (round_q),
    .sum_o   (sum_w)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    cap_en  = 1'b0;
    buf_en  = 1'b0;
    unique case (state_q)
      KS_IDLE: begin
        if (block_ready) begin
          cap_en  = 1'b1;
          state_d = KS_CAPTURE;
        end
      end
      KS_CAPTURE: state_d = KS_ADD;
      KS_ADD: begin
        buf_en  = 1'b1;
        idx_d   = '0;
        state_d = KS_STREAM;
      end
      KS_STREAM: begin
        if (ks_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = KS_IDLE;
          end
        end
      end
      default: state_d = KS_IDLE;
    endcase
    // Any pulse outside IDLE is dropped, including one on the final handshake.
    if (block_ready && (state_q != KS_IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KS_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q  <= '0;
      round_q <= '0;
      buf_q   <= '0;
    end else begin
      if (cap_en) begin
        init_q  <= init_state;
        round_q <= round_state;
      end
      if (buf_en) begin
        buf_q <= sum_w;
      end
    end
  end

  assign ks_valid       = (state_q == KS_STREAM);
  assign ks_word        = ks_valid ? buf_q[idx_q] : '0;
  assign ks_last        = ks_valid && (idx_q == 4'd15);
  assign busy           = (state_q != KS_IDLE);
  assign block_overrun  = ovr_q;
  assign blocks_emitted = cnt_q;

endmodule
